// File: rtl/jam_cost_table_pkg.sv
// rtl/jam_cost_table_pkg.sv - shared widths and state encoding for the cost table
package jam_cost_table_pkg;
  localparam int N       = 8;
  localparam int IDX_W   = 3;
  localparam int COST_W  = 7;
  localparam int ADDR_W  = 2 * IDX_W;
  localparam int DEPTH   = N * N;
  localparam int MIN_W   = 10;
  localparam int MATCH_W = 4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/jam_cost_mem.sv
// rtl/jam_cost_mem.sv - 64-entry cost array with sync write and registered read
module jam_cost_mem
  import jam_cost_table_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [COST_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [COST_W-1:0] rd_data
);

  logic [COST_W-1:0] mem [DEPTH];

  // Array write; contents deliberately survive reset and clear
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; drives zero whenever lookups are not being served
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/jam_cost_table.sv
// rtl/jam_cost_table.sv - cost-matrix responder: preload, lookup and result capture
module jam_cost_table
  import jam_cost_table_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               clear,
  input  logic               load_valid,
  input  logic [COST_W-1:0]  load_data,
  output logic               load_ready,
  output logic               Ready,
  input  logic [IDX_W-1:0]   W,
  input  logic [IDX_W-1:0]   J,
  output logic [COST_W-1:0]  Cost,
  input  logic               Valid,
  input  logic [MIN_W-1:0]   MinCost,
  input  logic [MATCH_W-1:0] MatchCount,
  output logic               res_valid,
  output logic [MIN_W-1:0]   res_min,
  output logic [MATCH_W-1:0] res_match
);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] ptr;
  logic              load_ready_q;
  logic              ready_q;
  logic              serving;
  logic              wr_en;
  logic              capture;
  logic              load_ready_d;
  logic              ready_d;

  // State register plus the status flags, registered from the next state
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= ST_LOAD;
      load_ready_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state        <= state_nx;
      load_ready_q <= load_ready_d;
      ready_q      <= ready_d;
    end
  end

  // Next state; clear overrides every other event
  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = ST_LOAD;
    end else begin
      case (state)
        ST_LOAD:  if (wr_en && ptr == LAST_ADDR) state_nx = ST_SERVE;
        ST_SERVE: if (Valid) state_nx = ST_DONE;
        ST_DONE:  state_nx = ST_DONE;
        default:  state_nx = ST_LOAD;
      endcase
    end
  end

  // Output decode: handshake strobes and next-cycle status flags
  always_comb begin
    serving      = (state == ST_SERVE) || (state == ST_DONE);
    wr_en        = (state == ST_LOAD) && load_valid && load_ready_q && !clear;
    capture      = serving && Valid && !clear;
    load_ready_d = (state_nx == ST_LOAD);
    ready_d      = (state_nx != ST_LOAD);
  end

  // Preload pointer advances only on accepted words and restarts on clear
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (wr_en) begin
      ptr <= ptr + 1'b1;
    end
  end

  // Engine result capture; a later Valid overwrites, clear only drops the flag
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      res_valid <= 1'b0;
      res_min   <= '0;
      res_match <= '0;
    end else if (clear) begin
      res_valid <= 1'b0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_min   <= MinCost;
      res_match <= MatchCount;
    end
  end

  jam_cost_mem u_mem (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (wr_en),
    .wr_addr (ptr),
    .wr_data (load_data),
    .rd_en   (serving),
    .rd_addr ({W, J}),
    .rd_data (Cost)
  );

  assign load_ready = load_ready_q;
  assign Ready      = ready_q;

endmodule
